// File: rtl/bram_port_arbiter.sv
// Two-client arbiter in front of a simple dual-port, read-first BRAM.
// The read and write ports each get their own burst-limited arbiter, and read returns are tagged by client.

module bram_port_arb #(
    parameter int MAX_BURST = 4
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // state   | meaning
    // OWN_C0  | client 0 holds ownership; wins ties while cnt < MAX_BURST
    // OWN_C1  | client 1 holds ownership; wins ties while cnt < MAX_BURST
    typedef enum logic {OWN_C0 = 1'b0, OWN_C1 = 1'b1} owner_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    owner_t           owner, owner_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             gnt_c1;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            owner <= OWN_C0;
            cnt   <= '0;
        end else begin
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        gnt       = 2'b00;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        gnt_c1    = 1'b0;
        // Grants are held off during reset so nothing issued in that cycle takes effect.
        if (!i_RST) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (cnt < CNT_MAX) gnt = (owner == OWN_C1) ? 2'b10 : 2'b01;
                    else               gnt = (owner == OWN_C1) ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
        end
        gnt_c1 = gnt[1];
        if (gnt != 2'b00) begin
            if ((owner == OWN_C1) == gnt_c1) begin
                if (cnt < CNT_MAX) cnt_nxt = cnt + 1'b1;
            end else begin
                owner_nxt = gnt_c1 ? OWN_C1 : OWN_C0;
                cnt_nxt   = CNT_W'(1);
            end
        end
    end
endmodule

module bram_port_arbiter #(
    parameter int RAM_WIDTH  = 13,
    parameter int NB_ADDRESS = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [1:0]              i_rdReq,
    input  logic [2*NB_ADDRESS-1:0] i_rdAdd,
    output logic [1:0]              o_rdGnt,
    output logic [1:0]              o_rdValid,
    output logic [RAM_WIDTH-1:0]    o_rdData,
    input  logic [1:0]              i_wrReq,
    input  logic [2*NB_ADDRESS-1:0] i_wrAdd,
    input  logic [2*RAM_WIDTH-1:0]  i_wrData,
    output logic [1:0]              o_wrGnt,
    output logic                    o_wrEnable,
    output logic [NB_ADDRESS-1:0]   o_writeAdd,
    output logic [NB_ADDRESS-1:0]   o_readAdd,
    output logic [RAM_WIDTH-1:0]    o_data,
    input  logic [RAM_WIDTH-1:0]    i_data
);
    logic [1:0]            rd_tag;
    logic [NB_ADDRESS-1:0] rd_add_sel;
    logic [NB_ADDRESS-1:0] wr_add_sel;
    logic [RAM_WIDTH-1:0]  wr_data_sel;

    bram_port_arb #(.MAX_BURST(MAX_BURST)) u_rd_arb (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .req   (i_rdReq),
        .gnt   (o_rdGnt)
    );

    bram_port_arb #(.MAX_BURST(MAX_BURST)) u_wr_arb (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .req   (i_wrReq),
        .gnt   (o_wrGnt)
    );

    assign rd_add_sel  = o_rdGnt[1] ? i_rdAdd[NB_ADDRESS +: NB_ADDRESS] : i_rdAdd[0 +: NB_ADDRESS];
    assign wr_add_sel  = o_wrGnt[1] ? i_wrAdd[NB_ADDRESS +: NB_ADDRESS] : i_wrAdd[0 +: NB_ADDRESS];
    assign wr_data_sel = o_wrGnt[1] ? i_wrData[RAM_WIDTH +: RAM_WIDTH] : i_wrData[0 +: RAM_WIDTH];

    // BRAM read data is already registered; the tag pipeline lines up with it at N+2.
    assign o_rdData = i_data;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_readAdd  <= '0;
            rd_tag     <= '0;
            o_rdValid  <= '0;
            o_wrEnable <= 1'b0;
            o_writeAdd <= '0;
            o_data     <= '0;
        end else begin
            if (o_rdGnt != 2'b00) o_readAdd <= rd_add_sel;
            rd_tag     <= o_rdGnt;
            o_rdValid  <= rd_tag;
            o_wrEnable <= |o_wrGnt;
            if (o_wrGnt != 2'b00) begin
                o_writeAdd <= wr_add_sel;
                o_data     <= wr_data_sel;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a read-first BRAM model that has registered read data.
module tb_bram_port_arbiter;
    localparam int RW = 13;
    localparam int NA = 10;
    localparam int MB = 4;

    logic              i_CLK = 1'b0;
    logic              i_RST = 1'b1;
    logic [1:0]        i_rdReq = '0;
    logic [2*NA-1:0]   i_rdAdd = '0;
    logic [1:0]        o_rdGnt;
    logic [1:0]        o_rdValid;
    logic [RW-1:0]     o_rdData;
    logic [1:0]        i_wrReq = '0;
    logic [2*NA-1:0]   i_wrAdd = '0;
    logic [2*RW-1:0]   i_wrData = '0;
    logic [1:0]        o_wrGnt;
    logic              o_wrEnable;
    logic [NA-1:0]     o_writeAdd;
    logic [NA-1:0]     o_readAdd;
    logic [RW-1:0]     o_data;
    logic [RW-1:0]     i_data;

    logic [RW-1:0]     mem [0:(1<<NA)-1];

    int total = 0;
    int bad   = 0;

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) begin
        if (o_wrEnable) mem[o_writeAdd] <= o_data;
        i_data <= mem[o_readAdd];
    end

    bram_port_arbiter #(.RAM_WIDTH(RW), .NB_ADDRESS(NA), .MAX_BURST(MB)) dut (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_rdReq    (i_rdReq),
        .i_rdAdd    (i_rdAdd),
        .o_rdGnt    (o_rdGnt),
        .o_rdValid  (o_rdValid),
        .o_rdData   (o_rdData),
        .i_wrReq    (i_wrReq),
        .i_wrAdd    (i_wrAdd),
        .i_wrData   (i_wrData),
        .o_wrGnt    (o_wrGnt),
        .o_wrEnable (o_wrEnable),
        .o_writeAdd (o_writeAdd),
        .o_readAdd  (o_readAdd),
        .o_data     (o_data),
        .i_data     (i_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic do_reset();
        i_RST   = 1'b1;
        i_rdReq = '0;
        i_wrReq = '0;
        tick();
        tick();
        i_RST = 1'b0;
        #1;
    endtask

    task automatic wr_one(input int client, input int addr, input int data);
        i_wrReq  = (client == 1) ? 2'b10 : 2'b01;
        i_wrAdd  = {NA'(addr), NA'(addr)};
        i_wrData = {RW'(data), RW'(data)};
        #1;
        check_eq("wr_preload_gnt", 32'(o_wrGnt), (client == 1) ? 32'h2 : 32'h1);
        tick();
        i_wrReq = '0;
        tick();
    endtask

    logic [1:0] e_sw [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [1:0] e_sg [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    initial begin
        // reset values
        tick();
        check_eq("rst_rdGnt", 32'(o_rdGnt), 0);
        check_eq("rst_wrGnt", 32'(o_wrGnt), 0);
        check_eq("rst_rdValid", 32'(o_rdValid), 0);
        check_eq("rst_wrEnable", 32'(o_wrEnable), 0);
        check_eq("rst_writeAdd", 32'(o_writeAdd), 0);
        check_eq("rst_readAdd", 32'(o_readAdd), 0);
        check_eq("rst_data", 32'(o_data), 0);
        do_reset();

        // single read of preloaded address 5
        wr_one(0, 5, 13'h0ABC);
        i_rdReq = 2'b01;
        i_rdAdd = {NA'(0), NA'(5)};
        #1;
        check_eq("rd5_gnt", 32'(o_rdGnt), 32'h1);
        tick();
        i_rdReq = 2'b00;
        #1;
        check_eq("rd5_readAdd", 32'(o_readAdd), 5);
        check_eq("rd5_valid_n1", 32'(o_rdValid), 0);
        tick();
        check_eq("rd5_valid", 32'(o_rdValid), 32'h1);
        check_eq("rd5_data", 32'(o_rdData), 32'h0ABC);

        // both clients reading continuously from reset: bursts of four
        wr_one(0, 20, 13'h111);
        wr_one(0, 30, 13'h222);
        do_reset();
        i_rdAdd = {NA'(30), NA'(20)};
        for (int i = 0; i < 12; i++) begin
            i_rdReq = (i < 10) ? 2'b11 : 2'b00;
            #1;
            if (i < 10)
                check_eq("burst_gnt", 32'(o_rdGnt), ((i % 8) < 4) ? 32'h1 : 32'h2);
            if (i >= 2) begin
                check_eq("burst_valid", 32'(o_rdValid), (((i - 2) % 8) < 4) ? 32'h1 : 32'h2);
                check_eq("burst_data", 32'(o_rdData), (((i - 2) % 8) < 4) ? 32'h111 : 32'h222);
            end
            tick();
        end

        // client 1 writes alone for ten cycles, then client 0 reads them back
        do_reset();
        for (int i = 0; i < 10; i++) begin
            i_wrReq  = 2'b10;
            i_wrAdd  = {NA'(i), NA'(0)};
            i_wrData = {RW'(32'h100 + i), RW'(0)};
            #1;
            check_eq("wr1_gnt", 32'(o_wrGnt), 32'h2);
            tick();
        end
        i_wrReq = 2'b00;
        tick();
        check_eq("wr1_idle_en", 32'(o_wrEnable), 0);
        for (int i = 0; i < 12; i++) begin
            i_rdReq = (i < 10) ? 2'b01 : 2'b00;
            i_rdAdd = {NA'(0), NA'(i)};
            #1;
            if (i < 10) check_eq("rb_gnt", 32'(o_rdGnt), 32'h1);
            if (i >= 2) begin
                check_eq("rb_valid", 32'(o_rdValid), 32'h1);
                check_eq("rb_data", 32'(o_rdData), 32'h100 + i - 2);
            end
            tick();
        end

        // same-address read/write collision: read-first
        wr_one(0, 7, 13'h0011);
        i_wrReq  = 2'b01;
        i_wrAdd  = {NA'(0), NA'(7)};
        i_wrData = {RW'(0), RW'(13'h1FFF)};
        i_rdReq  = 2'b10;
        i_rdAdd  = {NA'(7), NA'(0)};
        #1;
        check_eq("coll_wrGnt", 32'(o_wrGnt), 32'h1);
        check_eq("coll_rdGnt", 32'(o_rdGnt), 32'h2);
        tick();
        i_wrReq = 2'b00;
        i_rdReq = 2'b01;
        i_rdAdd = {NA'(0), NA'(7)};
        #1;
        check_eq("coll_rdGnt2", 32'(o_rdGnt), 32'h1);
        check_eq("coll_wrEn", 32'(o_wrEnable), 1);
        tick();
        i_rdReq = 2'b00;
        #1;
        check_eq("coll_old_valid", 32'(o_rdValid), 32'h2);
        check_eq("coll_old_data", 32'(o_rdData), 32'h0011);
        tick();
        check_eq("coll_new_valid", 32'(o_rdValid), 32'h1);
        check_eq("coll_new_data", 32'(o_rdData), 32'h1FFF);

        // owner drops request mid-burst: handover and count restart
        do_reset();
        for (int i = 0; i < 7; i++) begin
            i_rdReq = e_sw[i];
            #1;
            check_eq("drop_gnt", 32'(o_rdGnt), 32'(e_sg[i]));
            tick();
        end
        i_rdReq = 2'b00;

        // reset in the middle of traffic
        do_reset();
        i_rdAdd = {NA'(30), NA'(20)};
        i_rdReq = 2'b10;
        tick();
        tick();
        i_rdReq  = 2'b00;
        i_wrReq  = 2'b01;
        i_wrAdd  = {NA'(0), NA'(9)};
        i_wrData = {RW'(0), RW'(13'h0555)};
        i_RST    = 1'b1;
        #1;
        check_eq("mid_rst_wrGnt", 32'(o_wrGnt), 0);
        check_eq("mid_rst_readAdd", 32'(o_readAdd), 0);
        tick();
        check_eq("mid_rst_valid", 32'(o_rdValid), 0);
        check_eq("mid_rst_wrEn", 32'(o_wrEnable), 0);
        i_RST   = 1'b0;
        i_wrReq = 2'b00;
        i_rdReq = 2'b11;
        #1;
        check_eq("post_rst_owner", 32'(o_rdGnt), 32'h1);
        tick();
        i_rdReq = 2'b00;
        #1;
        check_eq("post_rst_valid", 32'(o_rdValid), 0);
        check_eq("post_rst_wrEn", 32'(o_wrEnable), 0);
        tick();
        tick();
        check_eq("post_rst_mem9", 32'(mem[9]), 32'h109);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
